// File: rtl/flash_spi_arbiter.sv
// Configuration SPI flash pin arbiter.
// Shares flash_cs/flash_clk/flash_si/flash_so between the JTAG USER1 pass-through
// (raw TCK-domain pins) and an internal READ (0x03) engine. JTAG pre-empts the
// engine, and every session is separated by at least CS_GAP cycles of CS high.
module flash_spi_arbiter #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk_in,
  input  logic             jtag1_reset,
  input  logic             jtag_cs,
  input  logic             jtag_clk,
  input  logic             jtag_si,
  input  logic             rd_req,
  input  logic [23:0]      rd_addr,
  input  logic [LEN_W-1:0] rd_len,
  output logic             rd_ack,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_done,
  output logic             rd_abort,
  output logic             jtag_granted,
  output logic             collision,
  input  logic             collision_clr,
  output logic             flash_cs,
  output logic             flash_clk,
  output logic             flash_si,
  input  logic             flash_so
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;
  localparam logic [DivW-1:0] DivLoad = DivW'(CLK_DIV - 1);
  localparam logic [GapW-1:0] GapLoad = GapW'(CS_GAP);
  localparam logic [7:0]      CmdRead = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StJtag,
    StCmd,
    StData,
    StGap
  } state_e;

  state_e state_q, state_d;

  // jtag_cs synchroniser; only CS crosses, SCK/MOSI are passed straight through.
  logic jcs_meta, jcs_s;

  logic [GapW-1:0]  gap_q, gap_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [LEN_W-1:0] byte_q, byte_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      shift_q, shift_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             granted_q, granted_d;
  logic             coll_q, coll_d;
  logic             coll_set;
  logic             cs_q, cs_d;
  logic             sck_q, sck_d;
  logic             si_q, si_d;

  // Two-flop synchroniser for the JTAG chip select, idles high (deselected).
  always_ff @(posedge clk_in or posedge jtag1_reset) begin
    if (jtag1_reset) begin
      jcs_meta <= 1'b1;
      jcs_s    <= 1'b1;
    end else begin
      jcs_meta <= jtag_cs;
      jcs_s    <= jcs_meta;
    end
  end

  // State register; reset lands in the gap so CS is guaranteed high for CS_GAP cycles.
  always_ff @(posedge clk_in or posedge jtag1_reset) begin
    if (jtag1_reset) begin
      state_q   <= StGap;
      gap_q     <= GapLoad;
      div_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      len_q     <= '0;
      shift_q   <= '0;
      rx_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      granted_q <= 1'b0;
      coll_q    <= 1'b0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b1;
      si_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      len_q     <= len_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      granted_q <= granted_d;
      coll_q    <= coll_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      si_q      <= si_d;
    end
  end

  // Next-state logic: ownership sequencing, mode-3 shifter and session accounting.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    div_d     = div_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    len_d     = len_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ack_d     = 1'b0;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    granted_d = granted_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    si_d      = si_q;
    coll_set  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // JTAG wins a tie with rd_req.
        if (!jcs_s) begin
          granted_d = 1'b1;
          state_d   = StJtag;
        end else if (rd_req) begin
          ack_d   = 1'b1;
          len_d   = rd_len;
          shift_d = {CmdRead, rd_addr};
          cs_d    = 1'b0;
          sck_d   = 1'b1;
          si_d    = 1'b0;
          div_d   = DivLoad;
          bit_d   = '0;
          byte_d  = '0;
          state_d = StCmd;
        end
      end

      StJtag: begin
        if (jcs_s) begin
          granted_d = 1'b0;
          gap_d     = GapLoad;
          state_d   = StGap;
        end
      end

      StCmd, StData: begin
        if (!jcs_s) begin
          // Pre-empted: drop the session at once; the partial byte is discarded.
          cs_d     = 1'b1;
          sck_d    = 1'b1;
          si_d     = 1'b0;
          abort_d  = 1'b1;
          coll_set = 1'b1;
          bit_d    = '0;
          byte_d   = '0;
          gap_d    = GapLoad;
          state_d  = StGap;
        end else if (div_q != '0) begin
          div_d = div_q - DivW'(1);
        end else begin
          div_d = DivLoad;
          sck_d = ~sck_q;
          if (sck_q) begin
            // Falling edge: present the next MOSI bit.
            if (state_q == StCmd) begin
              si_d    = shift_q[31];
              shift_d = {shift_q[30:0], 1'b0};
            end else begin
              si_d = 1'b0;
            end
          end else if (state_q == StCmd) begin
            // Rising edge in the command phase: the flash latches the bit.
            if (bit_q == 5'd31) begin
              bit_d   = '0;
              state_d = StData;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end else begin
            // Rising edge in the data phase: sample MISO.
            rx_d = {rx_q[6:0], flash_so};
            if (bit_q == 5'd7) begin
              bit_d   = '0;
              data_d  = {rx_q[6:0], flash_so};
              valid_d = 1'b1;
              if (byte_q == len_q) begin
                cs_d    = 1'b1;
                done_d  = 1'b1;
                byte_d  = '0;
                gap_d   = GapLoad;
                state_d = StGap;
              end else begin
                byte_d = byte_q + LEN_W'(1);
              end
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end
      end

      StGap: begin
        cs_d  = 1'b1;
        sck_d = 1'b1;
        if (!jcs_s) begin
          coll_set = 1'b1;
        end
        if (gap_q <= GapW'(1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end

      default: begin
        state_d = StGap;
        gap_d   = GapLoad;
      end
    endcase

    // Sticky collision flag; a same-cycle set beats the clear.
    if (coll_set) begin
      coll_d = 1'b1;
    end else if (collision_clr) begin
      coll_d = 1'b0;
    end else begin
      coll_d = coll_q;
    end
  end

  // Pin mux: raw JTAG pins while the registered owner bit says JTAG, else the engine.
  always_comb begin
    if (granted_q) begin
      flash_cs  = jtag_cs;
      flash_clk = jtag_clk;
      flash_si  = jtag_si;
    end else begin
      flash_cs  = cs_q;
      flash_clk = sck_q;
      flash_si  = si_q;
    end
  end

  assign rd_ack       = ack_q;
  assign rd_data      = data_q;
  assign rd_valid     = valid_q;
  assign rd_done      = done_q;
  assign rd_abort     = abort_q;
  assign jtag_granted = granted_q;
  assign collision    = coll_q;

endmodule

// File: tb/tb_flash_spi_arbiter.sv
// Directed bench for flash_spi_arbiter with a behavioural mode-3 flash model and a
// byte scoreboard fed when each read is requested.
module tb_flash_spi_arbiter;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned CS_GAP  = 4;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned TCLK    = 10;

  logic             clk_in        = 1'b0;
  logic             jtag1_reset   = 1'b1;
  logic             jtag_cs       = 1'b1;
  logic             jtag_clk      = 1'b1;
  logic             jtag_si       = 1'b0;
  logic             rd_req        = 1'b0;
  logic [23:0]      rd_addr       = '0;
  logic [LEN_W-1:0] rd_len        = '0;
  logic             collision_clr = 1'b0;
  logic             flash_so      = 1'b0;
  logic             rd_ack, rd_valid, rd_done, rd_abort, jtag_granted, collision;
  logic             flash_cs, flash_clk, flash_si;
  logic [7:0]       rd_data;

  int tests = 0;
  int fails = 0;

  flash_spi_arbiter #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP),
    .LEN_W   (LEN_W)
  ) dut (
    .clk_in        (clk_in),
    .jtag1_reset   (jtag1_reset),
    .jtag_cs       (jtag_cs),
    .jtag_clk      (jtag_clk),
    .jtag_si       (jtag_si),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_len        (rd_len),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_done       (rd_done),
    .rd_abort      (rd_abort),
    .jtag_granted  (jtag_granted),
    .collision     (collision),
    .collision_clr (collision_clr),
    .flash_cs      (flash_cs),
    .flash_clk     (flash_clk),
    .flash_si      (flash_si),
    .flash_so      (flash_so)
  );

  always #(TCLK / 2) clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Flash contents: two fixed bytes for the first read, a hash everywhere else.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (a == 24'h012345) return 8'hA5;
    if (a == 24'h012346) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Flash model (mode 3): latch MOSI on SCK rise, drive MISO on SCK fall.
  int          nbits    = 0;
  int          k_m;
  logic [31:0] cmd_sr   = '0;
  logic [31:0] last_cmd = '0;
  logic [7:0]  byte_m;
  time         last_rise;
  bit          have_rise = 1'b0;
  time         per_min   = 64'hFFFF_FFFF;
  time         per_max   = 0;
  time         cs_rise_t = 0;
  time         gap_min   = 64'hFFFF_FFFF;

  always @(posedge flash_cs) begin
    nbits     = 0;
    have_rise = 1'b0;
    cs_rise_t = $time;
  end

  always @(negedge flash_cs) begin
    if ($time - cs_rise_t < gap_min) gap_min = $time - cs_rise_t;
  end

  always @(posedge flash_clk) begin
    if (!flash_cs && !jtag_granted) begin
      if (nbits < 32) begin
        cmd_sr = {cmd_sr[30:0], flash_si};
        if (nbits == 31) last_cmd = cmd_sr;
      end
      nbits++;
      if (have_rise) begin
        if ($time - last_rise < per_min) per_min = $time - last_rise;
        if ($time - last_rise > per_max) per_max = $time - last_rise;
      end
      last_rise = $time;
      have_rise = 1'b1;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_cs && !jtag_granted) begin
      if (nbits >= 32) begin
        k_m      = nbits - 32;
        byte_m   = flash_byte(cmd_sr[23:0] + 24'(k_m / 8));
        flash_so = byte_m[7 - (k_m % 8)];
      end else begin
        flash_so = 1'b0;
      end
    end
  end

  // Scoreboard and pulse counters, sampled mid-cycle.
  logic [7:0] exp_q[$];
  int n_ack = 0, n_done = 0, n_abort = 0, n_valid = 0;

  always @(negedge clk_in) begin
    if (rd_ack) n_ack++;
    if (rd_done) n_done++;
    if (rd_abort) n_abort++;
    if (rd_valid) begin
      n_valid++;
      if (exp_q.size() == 0) check("rd_valid_unexpected", 1, 0);
      else check("rd_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic push_read(input logic [23:0] addr, input int nbytes);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(flash_byte(addr + 24'(i)));
  endtask

  task automatic wait_ack(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_in);
      if (rd_ack) break;
    end
    check(tag, rd_ack, 1'b1);
    rd_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_in);
      if (rd_done) break;
    end
    check(tag, rd_done, 1'b1);
    #1;
  endtask

  task automatic wait_ungrant(input string tag);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (!jtag_granted) break;
    end
    check(tag, jtag_granted, 1'b0);
  endtask

  initial begin
    #(200000 * TCLK);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int a0, d0, b0, v0, lat;
  logic cs_ok;
  logic [7:0] pat;

  initial begin
    // Reset values.
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_pins", {flash_cs, flash_clk, flash_si}, 3'b110);
    check("reset_pulses", {rd_ack, rd_valid, rd_done, rd_abort}, 4'b0000);
    check("reset_data", rd_data, 8'h00);
    check("reset_flags", {jtag_granted, collision}, 2'b00);
    @(negedge clk_in);
    jtag1_reset = 1'b0;
    repeat (4) @(negedge clk_in);

    // Basic two-byte read.
    a0 = n_ack; d0 = n_done; v0 = n_valid;
    per_min = 64'hFFFF_FFFF; per_max = 0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    rd_addr = 24'h012345; rd_len = 16'd1; rd_req = 1'b1;
    wait_ack("t1_ack", 20);
    wait_done("t1_done");
    check("t1_cmd", last_cmd, 32'h03012345);
    check("t1_sck_min", per_min, 2 * CLK_DIV * TCLK);
    check("t1_sck_max", per_max, 2 * CLK_DIV * TCLK);
    check("t1_nvalid", n_valid - v0, 2);
    check("t1_nack", n_ack - a0, 1);
    cs_ok = 1'b1;
    for (int i = 0; i < CS_GAP; i++) begin
      @(negedge clk_in);
      cs_ok &= flash_cs;
    end
    check("t1_cs_high_after", cs_ok, 1'b1);
    check("t1_ndone", n_done - d0, 1);
    check("t1_queue_empty", exp_q.size(), 0);
    repeat (6) @(negedge clk_in);

    // JTAG pass-through from idle.
    a0 = n_ack;
    jtag_cs = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in);
      #1;
      lat++;
      if (jtag_granted) break;
    end
    check("t2_grant_latency", lat, 3);
    check("t2_cs_mirror", flash_cs, 1'b0);
    pat = 8'b0110_1001;
    for (int i = 0; i < 4; i++) begin
      jtag_clk = pat[2*i];
      jtag_si  = pat[2*i+1];
      #2;
      check("t2_mirror", {flash_clk, flash_si}, {pat[2*i], pat[2*i+1]});
    end
    jtag_clk = 1'b1; jtag_si = 1'b0;
    @(negedge clk_in);
    jtag_cs = 1'b1;
    #1;
    check("t2_cs_release", flash_cs, 1'b1);
    wait_ungrant("t2_ungrant");
    check("t2_no_collision", collision, 1'b0);
    check("t2_no_ack", n_ack - a0, 0);
    repeat (8) @(negedge clk_in);

    // JTAG pre-empts a 4-byte read during byte 1; only byte 0 is delivered.
    d0 = n_done; b0 = n_abort; v0 = n_valid;
    push_read(24'h00F0F0, 1);
    rd_addr = 24'h00F0F0; rd_len = 16'd3; rd_req = 1'b1;
    wait_ack("t3_ack", 20);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      if (rd_valid) break;
    end
    check("t3_first_byte", rd_valid, 1'b1);
    repeat (2) @(negedge clk_in);
    jtag_cs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (rd_abort) break;
    end
    check("t3_abort", rd_abort, 1'b1);
    check("t3_pins_released", {flash_cs, flash_clk}, 2'b11);
    // Clear lands in a gap cycle that is also setting collision.
    collision_clr = 1'b1;
    lat = 0;
    @(negedge clk_in);
    lat++;
    collision_clr = 1'b0;
    check("t3_set_beats_clr", collision, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (jtag_granted) break;
      @(negedge clk_in);
      lat++;
    end
    check("t3_grant_after_gap", (lat >= CS_GAP + 1) && (lat <= CS_GAP + 2), 1'b1);
    #1;
    check("t3_nabort", n_abort - b0, 1);
    check("t3_no_done", n_done - d0, 0);
    check("t3_nvalid", n_valid - v0, 1);
    check("t3_queue_empty", exp_q.size(), 0);
    collision_clr = 1'b1;
    @(negedge clk_in);
    collision_clr = 1'b0;
    check("t3_clr_alone", collision, 1'b0);
    jtag_cs = 1'b1;
    wait_ungrant("t3_ungrant");
    repeat (8) @(negedge clk_in);

    // rd_req and synchronised JTAG CS arrive in the same idle cycle: JTAG first.
    a0 = n_ack; d0 = n_done; v0 = n_valid;
    jtag_cs = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    push_read(24'h000100, 3);
    rd_addr = 24'h000100; rd_len = 16'd2; rd_req = 1'b1;
    @(posedge clk_in);
    #1;
    check("t4_jtag_first", jtag_granted, 1'b1);
    repeat (10) @(negedge clk_in);
    check("t4_no_ack_during_jtag", n_ack - a0, 0);
    jtag_cs = 1'b1;
    wait_ack("t4_ack_after", 40);
    wait_done("t4_done");
    check("t4_cmd", last_cmd, 32'h03000100);
    check("t4_nvalid", n_valid - v0, 3);
    check("t4_collision", collision, 1'b0);
    repeat (8) @(negedge clk_in);

    // Asynchronous reset in the command phase.
    d0 = n_done; b0 = n_abort;
    rd_addr = 24'h777777; rd_len = 16'd0; rd_req = 1'b1;
    wait_ack("t5_ack", 20);
    repeat (10) @(negedge clk_in);
    #3;
    jtag1_reset = 1'b1;
    #1;
    check("t5_reset_pins", {flash_cs, flash_clk, flash_si}, 3'b110);
    check("t5_reset_pulses", {rd_ack, rd_valid, rd_done, rd_abort}, 4'b0000);
    check("t5_reset_data", rd_data, 8'h00);
    check("t5_reset_flags", {jtag_granted, collision}, 2'b00);
    repeat (2) @(negedge clk_in);
    jtag1_reset = 1'b0;
    repeat (6) @(negedge clk_in);
    check("t5_no_done_abort", {n_done - d0, n_abort - b0}, 0);
    v0 = n_valid;
    push_read(24'h0A0B0C, 1);
    rd_addr = 24'h0A0B0C; rd_len = 16'd0; rd_req = 1'b1;
    wait_ack("t5_ack_after", 20);
    wait_done("t5_done");
    check("t5_cmd", last_cmd, 32'h030A0B0C);
    check("t5_nvalid", n_valid - v0, 1);
    repeat (4) @(negedge clk_in);

    check("cs_gap_min", gap_min >= CS_GAP * TCLK, 1'b1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
